// File: rtl/status_register_unit_pkg.sv
// Shared definitions for the status register unit: EXE command encodings,
// status word bit positions and the default datapath width.
package status_register_unit_pkg;

  localparam int SRU_WIDTH_DEFAULT = 32;

  // Bit positions inside the {z,c,n,v} status word
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_MVN = 4'b1001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000
  } exe_cmd_e;

  // Assemble a status word from its individual flags
  function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                            input logic n, input logic v);
    logic [3:0] word;
    word         = 4'b0000;
    word[FLAG_Z] = z;
    word[FLAG_C] = c;
    word[FLAG_N] = n;
    word[FLAG_V] = v;
    return word;
  endfunction

endpackage

// File: rtl/status_register_unit_flag_gen.sv
// Combinational NZCV generation for one EXE-stage command.
// Arithmetic commands derive C and V from the WIDTH+1-bit sum; logic and
// move commands pass C and V through from the youngest older status word.
module status_flag_gen
  import status_register_unit_pkg::*;
#(
  parameter int WIDTH = SRU_WIDTH_DEFAULT
) (
  input  logic [3:0]       cmd_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             cin_i,
  input  logic             keep_c_i,
  input  logic             keep_v_i,
  output logic [3:0]       flags_o,
  output logic             defined_o
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] res_s;
  logic             c_s;
  logic             v_s;
  logic             n_s;
  logic             z_s;

  // Result, carry and overflow per command; subtraction is op1 + ~op2 + carry-in
  always_comb begin
    sum_s     = {(WIDTH+1){1'b0}};
    res_s     = {WIDTH{1'b0}};
    c_s       = keep_c_i;
    v_s       = keep_v_i;
    defined_o = 1'b1;
    case (cmd_i)
      CMD_ADD: begin
        sum_s = {1'b0, op1_i} + {1'b0, op2_i};
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (op1_i[WIDTH-1] == op2_i[WIDTH-1]) && (res_s[WIDTH-1] != op1_i[WIDTH-1]);
      end
      CMD_ADC: begin
        sum_s = {1'b0, op1_i} + {1'b0, op2_i} + {{WIDTH{1'b0}}, cin_i};
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (op1_i[WIDTH-1] == op2_i[WIDTH-1]) && (res_s[WIDTH-1] != op1_i[WIDTH-1]);
      end
      CMD_SUB: begin
        sum_s = {1'b0, op1_i} + {1'b0, ~op2_i} + {{WIDTH{1'b0}}, 1'b1};
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (op1_i[WIDTH-1] != op2_i[WIDTH-1]) && (res_s[WIDTH-1] != op1_i[WIDTH-1]);
      end
      CMD_SBC: begin
        sum_s = {1'b0, op1_i} + {1'b0, ~op2_i} + {{WIDTH{1'b0}}, cin_i};
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (op1_i[WIDTH-1] != op2_i[WIDTH-1]) && (res_s[WIDTH-1] != op1_i[WIDTH-1]);
      end
      CMD_MOV: res_s = op2_i;
      CMD_MVN: res_s = ~op2_i;
      CMD_AND: res_s = op1_i & op2_i;
      CMD_ORR: res_s = op1_i | op2_i;
      CMD_EOR: res_s = op1_i ^ op2_i;
      default: begin
        res_s     = {WIDTH{1'b0}};
        defined_o = 1'b0;
      end
    endcase
  end

  // N and Z are common to every command
  always_comb begin
    n_s     = res_s[WIDTH-1];
    z_s     = (res_s == {WIDTH{1'b0}});
    flags_o = pack_flags(z_s, c_s, n_s, v_s);
  end

endmodule

// File: rtl/status_register_unit.sv
// Status register unit: generates NZCV for the EXE-stage instruction,
// stages it in a one-entry pending register, commits it to the architectural
// status register on the following edge, and forwards the youngest status.
module status_register_unit
  import status_register_unit_pkg::*;
#(
  parameter int WIDTH = SRU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             exe_valid,
  input  logic             exe_s,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] exe_op1,
  input  logic [WIDTH-1:0] exe_op2,
  output logic             alu_cin,
  output logic [3:0]       sr,
  output logic [3:0]       sr_fwd,
  output logic             flags_busy
);

  logic [3:0] sr_q;
  logic [3:0] sr_d;
  logic       pend_valid_q;
  logic       pend_valid_d;
  logic [3:0] pend_flags_q;
  logic [3:0] pend_flags_d;

  logic [3:0] older_flags_s;
  logic [3:0] exe_flags_s;
  logic       exe_defined_s;
  logic       wr_s;

  // Youngest status excluding the EXE instruction itself; feeds carry-in and
  // the C/V pass-through so the EXE flags never depend on themselves
  always_comb begin
    if (pend_valid_q) begin
      older_flags_s = pend_flags_q;
    end else begin
      older_flags_s = sr_q;
    end
  end

  status_flag_gen #(
    .WIDTH(WIDTH)
  ) u_flag_gen (
    .cmd_i     (exe_cmd),
    .op1_i     (exe_op1),
    .op2_i     (exe_op2),
    .cin_i     (older_flags_s[FLAG_C]),
    .keep_c_i  (older_flags_s[FLAG_C]),
    .keep_v_i  (older_flags_s[FLAG_V]),
    .flags_o   (exe_flags_s),
    .defined_o (exe_defined_s)
  );

  // A flag write needs a real, S-bit, unflushed, defined instruction; it is
  // masked during reset so the forwarded word reads as cleared immediately
  always_comb begin
    wr_s = exe_valid & exe_s & ~flush & exe_defined_s & ~rst;
  end

  // Forwarding mux: EXE flags beat the pending entry, which beats sr
  always_comb begin
    if (wr_s) begin
      sr_fwd = exe_flags_s;
    end else begin
      sr_fwd = older_flags_s;
    end
  end

  // Next state: the pending entry commits to sr while a new write reloads it;
  // freeze holds everything and ignores the write on that edge
  always_comb begin
    sr_d         = sr_q;
    pend_valid_d = pend_valid_q;
    pend_flags_d = pend_flags_q;
    if (freeze) begin
      sr_d         = sr_q;
      pend_valid_d = pend_valid_q;
      pend_flags_d = pend_flags_q;
    end else begin
      if (pend_valid_q) begin
        sr_d = pend_flags_q;
      end else begin
        sr_d = sr_q;
      end
      pend_valid_d = wr_s;
      if (wr_s) begin
        pend_flags_d = exe_flags_s;
      end else begin
        pend_flags_d = pend_flags_q;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q         <= 4'b0000;
      pend_valid_q <= 1'b0;
      pend_flags_q <= 4'b0000;
    end else begin
      sr_q         <= sr_d;
      pend_valid_q <= pend_valid_d;
      pend_flags_q <= pend_flags_d;
    end
  end

  assign sr         = sr_q;
  assign flags_busy = pend_valid_q;
  assign alu_cin    = older_flags_s[FLAG_C];

endmodule
